// File: rtl/cnn_mac_pipe_sxu_if.sv
// ---------------------------------------------------------------------------
// cnn_mac_pipe_sxu_if
//   Beat/result bundle between a pixel/weight source and the pipelined MAC.
//   The source side (master) drives the clock enable, the framed operand beat
//   (in_valid/in_first/in_last, din0, din1). It receives the finished sum
//   (out_valid, dout, overflow).
//   master : ce, in_valid, in_first, in_last, din0, din1 out; out_valid, dout, overflow in
//   slave  : mirror of master (used by cnn_mac_pipe_sxu)
// ---------------------------------------------------------------------------
interface cnn_mac_pipe_sxu_if #(
   parameter int din0_WIDTH = 14,
   parameter int din1_WIDTH = 9,
   parameter int dout_WIDTH = 32
);
   logic                         ce;
   logic                         in_valid;
   logic                         in_first;
   logic                         in_last;
   logic signed [din0_WIDTH-1:0] din0;
   logic        [din1_WIDTH-1:0] din1;
   logic                         out_valid;
   logic signed [dout_WIDTH-1:0] dout;
   logic                         overflow;

   modport master (
      output ce, in_valid, in_first, in_last, din0, din1,
      input  out_valid, dout, overflow
   );

   modport slave (
      input  ce, in_valid, in_first, in_last, din0, din1,
      output out_valid, dout, overflow
   );
endinterface

// File: rtl/cnn_mac_pipe_sxu.sv
// ---------------------------------------------------------------------------
// cnn_mac_pipe_sxu
//   Pipelined multiply-accumulate for convolution inner loops. Each accepted
//   beat forms the exact product din0*din1, which travels NUM_STAGE-1 product
//   registers. It then lands in the accumulator. A first beat restarts the sum and
//   a last beat publishes it on dout with a one-ce-cycle out_valid pulse.
//   ce=0 freezes every register.
//
//   Ports: ap_clk, ap_rst (sync, active-high) plus bus (cnn_mac_pipe_sxu_if.slave):
//     ce, in_valid, in_first, in_last, din0, din1  -> beat in
//     out_valid, dout, overflow                     <- result out
//
//   Optional feature macro CNN_MAC_SAT_EN:
//     defined   : accumulator saturates, sticky overflow flag per sum
//     undefined : accumulator wraps, overflow tied low
// ---------------------------------------------------------------------------
module cnn_mac_pipe_sxu #(
   parameter int din0_WIDTH = 14,
   parameter int din1_WIDTH = 9,
   parameter int dout_WIDTH = 32,
   parameter int NUM_STAGE  = 3,
   parameter int B_SIGNED   = 0
) (
   input logic              ap_clk,
   input logic              ap_rst,
   cnn_mac_pipe_sxu_if.slave bus
);
   localparam int PW = din0_WIDTH + din1_WIDTH;
   localparam int NP = NUM_STAGE - 1;

   // B carries one extra bit so the unsigned case multiplies as {1'b0,B}.
   logic signed [din1_WIDTH:0]   b_ext;
   logic signed [PW-1:0]         prod_p0;

   logic signed [PW-1:0]         prod_acc;
   logic                         vld_acc;
   logic                         first_acc;
   logic                         last_acc;

   logic signed [dout_WIDTH-1:0] acc_q, acc_d;
   logic signed [dout_WIDTH-1:0] dout_q, dout_d;
   logic                         out_valid_q, out_valid_d;
   logic signed [dout_WIDTH-1:0] prod_ext;
   logic signed [dout_WIDTH-1:0] acc_base;
   logic signed [dout_WIDTH-1:0] acc_new;

   // ---- stage p0: operand extension and exact product ----
   always_comb begin
      b_ext   = (B_SIGNED != 0) ? {bus.din1[din1_WIDTH-1], bus.din1} : {1'b0, bus.din1};
      prod_p0 = PW'(bus.din0) * PW'(b_ext);
   end

   // ---- product pipeline: NUM_STAGE-1 registers ----
   if (NUM_STAGE == 1) begin : g_no_pipe
      assign prod_acc  = prod_p0;
      assign vld_acc   = bus.in_valid;
      assign first_acc = bus.in_first;
      assign last_acc  = bus.in_last;
   end else begin : g_pipe
      logic signed [PW-1:0] prod_q [NP];
      logic signed [PW-1:0] prod_d [NP];
      logic [NP-1:0]        vld_q, vld_d;
      logic [NP-1:0]        first_q, first_d;
      logic [NP-1:0]        last_q, last_d;

      always_comb begin
         prod_d  = prod_q;
         vld_d   = vld_q;
         first_d = first_q;
         last_d  = last_q;
         if (bus.ce) begin
            prod_d[0]  = prod_p0;
            vld_d[0]   = bus.in_valid;
            first_d[0] = bus.in_first;
            last_d[0]  = bus.in_last;
            for (int i = 1; i < NP; i++) begin
               prod_d[i]  = prod_q[i-1];
               vld_d[i]   = vld_q[i-1];
               first_d[i] = first_q[i-1];
               last_d[i]  = last_q[i-1];
            end
         end
      end

      always_ff @(posedge ap_clk) begin
         prod_q <= prod_d;
         if (ap_rst) begin
            vld_q   <= '0;
            first_q <= '0;
            last_q  <= '0;
         end else begin
            vld_q   <= vld_d;
            first_q <= first_d;
            last_q  <= last_d;
         end
      end

      assign prod_acc  = prod_q[NP-1];
      assign vld_acc   = vld_q[NP-1];
      assign first_acc = first_q[NP-1];
      assign last_acc  = last_q[NP-1];
   end

`ifdef CNN_MAC_SAT_EN
   logic                         overflow_q, overflow_d;
   logic                         ovf_now;
   logic signed [dout_WIDTH:0]   sum_wide;

   // Clamp a one-bit-wider sum into dout_WIDTH; the top two bits disagree on overflow.
   function automatic logic signed [dout_WIDTH-1:0] sat_fn(input logic signed [dout_WIDTH:0] s);
      if (s[dout_WIDTH] != s[dout_WIDTH-1])
         return s[dout_WIDTH] ? {1'b1, {(dout_WIDTH-1){1'b0}}} : {1'b0, {(dout_WIDTH-1){1'b1}}};
      return s[dout_WIDTH-1:0];
   endfunction
`endif

   // ---- accumulator stage ----
   always_comb begin
      prod_ext = dout_WIDTH'(prod_acc);
      acc_base = first_acc ? '0 : acc_q;
`ifdef CNN_MAC_SAT_EN
      sum_wide = (dout_WIDTH+1)'(acc_base) + (dout_WIDTH+1)'(prod_ext);
      ovf_now  = sum_wide[dout_WIDTH] != sum_wide[dout_WIDTH-1];
      acc_new  = sat_fn(sum_wide);
`else
      acc_new  = acc_base + prod_ext;
`endif

      acc_d       = acc_q;
      dout_d      = dout_q;
      out_valid_d = out_valid_q;
`ifdef CNN_MAC_SAT_EN
      overflow_d  = overflow_q;
`endif
      if (bus.ce) begin
         out_valid_d = 1'b0;
         if (vld_acc) begin
            acc_d = acc_new;
`ifdef CNN_MAC_SAT_EN
            // Sticky within a sum; a first beat starts a fresh flag.
            overflow_d = (first_acc ? 1'b0 : overflow_q) | ovf_now;
`endif
            if (last_acc) begin
               dout_d      = acc_new;
               out_valid_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         acc_q       <= '0;
         dout_q      <= '0;
         out_valid_q <= 1'b0;
`ifdef CNN_MAC_SAT_EN
         overflow_q  <= 1'b0;
`endif
      end else begin
         acc_q       <= acc_d;
         dout_q      <= dout_d;
         out_valid_q <= out_valid_d;
`ifdef CNN_MAC_SAT_EN
         overflow_q  <= overflow_d;
`endif
      end
   end

   assign bus.dout      = dout_q;
   assign bus.out_valid = out_valid_q;
`ifdef CNN_MAC_SAT_EN
   assign bus.overflow  = overflow_q;
`else
   assign bus.overflow  = 1'b0;
`endif
endmodule
